// File: rtl/ram_toggle_pkg.sv
// Shared types and helpers for the RAM toggle tester: FSM state encoding
// and the debounce counter width function.
package ram_toggle_pkg;

  typedef enum logic [2:0] {
    INIT_RD,
    INIT_WT,
    IDLE,
    RD,
    WT,
    WR
  } state_t;

  // Counter must hold values up to DEBOUNCE_CYCLES; never narrower than 1 bit.
  function automatic int debounce_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser plus an optional stable-level
// debounce counter (enabled by RAM_TOGGLE_DEBOUNCE_EN). Output idles high (released).
module btn_debounce
  import ram_toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

`ifdef RAM_TOGGLE_DEBOUNCE_EN
  localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Any return to the current output level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b1;
    end else if (sync_q[1] == btn_db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      btn_db <= sync_q[1];
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic [31:0] unused_cycles;

  assign unused_cycles = DEBOUNCE_CYCLES;
  assign btn_db        = sync_q[1];
`endif

endmodule

// File: rtl/ram_toggle_tester.sv
// Multi-channel RAM toggle tester: debounced presses queue read-modify-writes on a
// shared RAM word per channel, served round-robin. Debounce via RAM_TOGGLE_DEBOUNCE_EN.
module ram_toggle_tester
  import ram_toggle_pkg::*;
#(
  parameter int             NCH             = 2,
  parameter int             DW              = 32,
  parameter int             AW              = 16,
  parameter int             BASE_ADDR       = 1,
  parameter logic [DW-1:0]  TOGGLE_MASK     = 1,
  parameter int             DEBOUNCE_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] buttons,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  output logic           ram_we,
  input  logic [DW-1:0]  ram_rdata,
  output logic [NCH-1:0] leds,
  output logic           busy
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state;
  logic [NCH-1:0] db;
  logic [NCH-1:0] db_q;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grant_clr;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] ch;
  logic [CHW-1:0] k;
  logic [CHW-1:0] grant_idx;
  logic           grant_valid;
  logic [AW-1:0]  addr_sel;

  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(buttons[i]),
      .btn_db (db[i])
    );
  end

  // Scanning downwards lets the channel closest to ptr overwrite the others.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = NCH - 1; off >= 0; off--) begin
      if (pend[rr_idx(ptr, off)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx(ptr, off);
      end
    end
    grant_clr = '0;
    if (state == IDLE && grant_valid) grant_clr = NCH'(1) << grant_idx;
  end

  // Release-to-press edges set pend; a new press wins over a same-cycle grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '1;
      pend <= '0;
    end else begin
      db_q <= db;
      pend <= (pend & ~grant_clr) | (db_q & ~db);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_RD;
      k         <= '0;
      ch        <= '0;
      ptr       <= '0;
      ram_wdata <= '0;
      leds      <= '0;
    end else begin
      case (state)
        INIT_RD: state <= INIT_WT;
        INIT_WT: begin
          leds[k] <= ram_rdata[0];
          if (k == CHW'(NCH - 1)) begin
            state <= IDLE;
          end else begin
            k     <= k + CHW'(1);
            state <= INIT_RD;
          end
        end
        IDLE: begin
          if (grant_valid) begin
            ch    <= grant_idx;
            ptr   <= (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);
            state <= RD;
          end
        end
        RD: state <= WT;
        WT: begin
          ram_wdata <= ram_rdata ^ TOGGLE_MASK;
          state     <= WR;
        end
        WR: begin
          leds[ch] <= ram_wdata[0];
          state    <= IDLE;
        end
        default: state <= INIT_RD;
      endcase
    end
  end

  // The address must be on the port during INIT_RD/RD itself, so it is decoded
  // from state; it is forced to zero while reset is held.
  always_comb begin
    addr_sel = '0;
    case (state)
      INIT_RD, INIT_WT: addr_sel = AW'(BASE_ADDR) + AW'(k);
      RD, WT, WR:       addr_sel = AW'(BASE_ADDR) + AW'(ch);
      default:          addr_sel = '0;
    endcase
  end

  assign ram_addr = rst_n ? addr_sel : '0;
  assign ram_we   = (state == WR);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_toggle_tester.sv
// Self-checking bench for ram_toggle_tester: behavioural RAM, a word/LED model
// with a round-robin write predictor, and a per-cycle compare process.
module tb_ram_toggle_tester;

  localparam int            NCH  = 2;
  localparam int            DW   = 32;
  localparam int            AW   = 16;
  localparam int            BASE = 1;
  localparam logic [DW-1:0] MASK = 32'h1;
`ifdef RAM_TOGGLE_DEBOUNCE_EN
  localparam int DEB        = 8;
  localparam int PRESS_HOLD = 10;
  localparam int PRESS_GAP  = 14;
  localparam logic [31:0] S6_W0   = 32'h1;
  localparam logic [1:0]  S6_LEDS = 2'b11;
`else
  localparam int DEB        = 50000;
  localparam int PRESS_HOLD = 1;
  localparam int PRESS_GAP  = 2;
  localparam logic [31:0] S6_W0   = 32'h0;
  localparam logic [1:0]  S6_LEDS = 2'b10;
`endif

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] buttons;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_wdata;
  logic           ram_we;
  logic [DW-1:0]  ram_rdata;
  logic [NCH-1:0] leds;
  logic           busy;

  logic [DW-1:0]  mem [0:15];
  logic [DW-1:0]  exp_word [0:NCH-1];
  logic [NCH-1:0] exp_leds;
  wr_t            exp_q [$];
  wr_t            e;
  int             write_cycles [$];
  int             model_ptr;
  int             cycle = 0;
  int             checks = 0;
  int             failures = 0;

  ram_toggle_tester #(
    .NCH(NCH), .DW(DW), .AW(AW), .BASE_ADDR(BASE), .TOGGLE_MASK(MASK), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .leds(leds), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[3:0]];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Predict the writes for presses landing together: round-robin from model_ptr.
  task automatic pushRoundRobin(input logic [NCH-1:0] mask);
    int base;
    base = model_ptr;
    for (int off = 0; off < NCH; off++) begin
      int c;
      c = (base + off) % NCH;
      if (mask[c]) begin
        exp_word[c] = exp_word[c] ^ MASK;
        exp_q.push_back('{ch: c, addr: AW'(BASE + c), data: exp_word[c]});
        model_ptr = (c + 1) % NCH;
      end
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask, input int hold);
    @(posedge clk); #1;
    buttons = ~mask;
    repeat (hold) @(posedge clk);
    #1;
    buttons = '1;
    repeat (PRESS_GAP) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got pending=%0d busy=%0b, required 0 and 0", tag, exp_q.size(), busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkInitScan(input logic [NCH-1:0] want_leds);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_busy_c3", busy, 1'b1);
    @(posedge clk); #1;
    checkOutput("init_busy_c4", busy, 1'b0);
    checkOutput("init_leds", leds, want_leds);
  endtask

  // Compare process: LEDs whenever idle, every write against the predicted queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) checkOutput("leds_idle", leds, exp_leds);
      if (ram_we) begin
        write_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", ram_addr, e.addr);
          checkOutput("wr_data", ram_wdata, e.data);
          exp_leds[e.ch] = e.data[0];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wb;
    int n;
    rst_n   = 1'b0;
    buttons = '1;
    for (int i = 0; i < 16; i++) mem[i] = 32'hCAFE_0000 + 32'(i);
    mem[0]      = 32'hDEAD_BEEF;
    mem[BASE]   = 32'h1;
    mem[BASE+1] = 32'h0;
    exp_word[0] = 32'h1;
    exp_word[1] = 32'h0;
    model_ptr   = 0;
    exp_leds    = {exp_word[1][0], exp_word[0][0]};

    // Reset values and the init scan.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_we", ram_we, 1'b0);
    checkOutput("rst_addr", ram_addr, 16'h0);
    checkOutput("rst_wdata", ram_wdata, 32'h0);
    checkOutput("rst_leds", leds, 2'b00);
    checkInitScan(2'b01);

    // Single press on channel 0.
    wb = write_cycles.size();
    pushRoundRobin(2'b01);
    applyStimulus(2'b01, PRESS_HOLD);
    waitDone("s2", 200);
    checkOutput("s2_writes", write_cycles.size() - wb, 1);
    checkOutput("s2_word", mem[BASE], 32'h0);
    checkOutput("s2_leds", leds, 2'b00);

    // Channel 1 alone, which brings the pointer back to 0.
    pushRoundRobin(2'b10);
    applyStimulus(2'b10, PRESS_HOLD);
    waitDone("s3", 200);
    checkOutput("s3_word", mem[BASE+1], 32'h1);
    checkOutput("s3_leds", leds, 2'b10);

    // Both channels in the same cycle: ch0 then ch1, back to back.
    wb = write_cycles.size();
    pushRoundRobin(2'b11);
    applyStimulus(2'b11, PRESS_HOLD);
    waitDone("s4", 200);
    checkOutput("s4_writes", write_cycles.size() - wb, 2);
    if (write_cycles.size() - wb == 2)
      checkOutput("s4_spacing", write_cycles[wb+1] - write_cycles[wb], 4);
    checkOutput("s4_word0", mem[BASE], 32'h1);
    checkOutput("s4_word1", mem[BASE+1], 32'h0);
    checkOutput("s4_leds", leds, 2'b01);
    checkOutput("s4_untouched_lo", mem[0], 32'hDEAD_BEEF);
    checkOutput("s4_untouched_hi", mem[BASE+2], 32'hCAFE_0003);

`ifdef RAM_TOGGLE_DEBOUNCE_EN
    // Short glitches must be filtered; a long hold gives exactly one RMW.
    wb = write_cycles.size();
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      buttons = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      buttons = 2'b11;
      repeat (3) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitch_writes", write_cycles.size() - wb, 0);
    checkOutput("glitch_busy", busy, 1'b0);
    pushRoundRobin(2'b10);
    applyStimulus(2'b10, 10);
    waitDone("s5", 200);
    checkOutput("hold_writes", write_cycles.size() - wb, 1);
    checkOutput("s5_word1", mem[BASE+1], 32'h1);
    checkOutput("s5_leds", leds, 2'b11);
`else
    // Two ch0 presses while ch1 is being served coalesce into one write.
    wb = write_cycles.size();
    pushRoundRobin(2'b10);
    pushRoundRobin(2'b01);
    @(posedge clk); #1; buttons = 2'b01;
    @(posedge clk); #1; buttons = 2'b10;
    @(posedge clk); #1; buttons = 2'b11;
    @(posedge clk); #1; buttons = 2'b10;
    @(posedge clk); #1; buttons = 2'b11;
    waitDone("s5", 200);
    checkOutput("coalesce_writes", write_cycles.size() - wb, 2);
    checkOutput("s5_word0", mem[BASE], 32'h0);
    checkOutput("s5_word1", mem[BASE+1], 32'h1);
    checkOutput("s5_leds", leds, 2'b10);
`endif

    // Reset asserted inside the WR cycle abandons the write.
    @(posedge clk); #1;
    buttons = 2'b10;
    repeat (PRESS_HOLD) @(posedge clk);
    #1;
    buttons = '1;
    n = 0;
    while (!ram_we && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("[TB] FAIL s6_timeout: got no write strobe, required one within 60 cycles");
    end
    rst_n = 1'b0;
    #1;
    checkOutput("s6_we_async", ram_we, 1'b0);
    checkOutput("s6_addr_rst", ram_addr, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("s6_word_kept", mem[BASE], S6_W0);
    checkOutput("s6_leds_rst", leds, 2'b00);
    exp_leds  = {exp_word[1][0], exp_word[0][0]};
    model_ptr = 0;
    checkInitScan(S6_LEDS);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("s6_no_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_toggle_tester.md
# ram_toggle_tester

Multi-channel successor to the board-level RAM toggle test on the DE0 top. Each of NCH push-buttons owns one word in a shared single-port RAM; a debounced press performs a read-modify-write that inverts a masked field of that word and mirrors bit 0 onto the channel's LED. A round-robin arbiter serialises the channels onto the single RAM port, and an init scan loads the LEDs from RAM after reset. The block sits in compsys_de0 between the board buttons/LEDs and a ram instance.

## Interface
- NCH, 2: number of channels (1..10)
- DW, 32: RAM data width
- AW, 16: RAM address width
- BASE_ADDR, 1: address of channel 0; channel i uses BASE_ADDR+i
- TOGGLE_MASK, 1 (DW bits): bits inverted on each press
- DEBOUNCE_CYCLES, 50000: stable-level cycles required (1 ms at 50 MHz)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- buttons  in  NCH  raw board buttons, active-low (0 = pressed)
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_addr is presented with ram_we=0
- leds  out  NCH  bit 0 of each channel's word after its last completed RMW
- busy  out  1  high while init scan or any RMW is in progress

## Operation
- Inputs: each buttons[i] passes a 2-flop synchroniser, then the debouncer, then a falling-edge detector (release-to-press). One pulse per press.
- Pending: a press pulse sets pend[i]. A press while pend[i] is already set is coalesced (lost). pend[i] clears when channel i is granted.
- Arbiter: in IDLE, grant the lowest-index pending channel at or after ptr (round-robin); ptr <= grant+1, wrapping NCH-1 -> 0.
- FSM states: INIT_RD, INIT_WT, IDLE, RD, WT, WR.
  - INIT_RD: ram_addr = BASE_ADDR+k, ram_we=0 -> INIT_WT.
  - INIT_WT: leds[k] <= ram_rdata[0]; if k==NCH-1 -> IDLE, else k++ -> INIT_RD.
  - IDLE: if any pend -> RD with grant latched into ch.
  - RD: ram_addr = BASE_ADDR+ch, ram_we=0 -> WT.
  - WT: capture ram_rdata into rd_q -> WR.
  - WR: ram_addr = BASE_ADDR+ch, ram_wdata = rd_q ^ TOGGLE_MASK, ram_we=1; leds[ch] <= bit 0 of that value -> IDLE.
- Presses arriving during INIT are recorded in pend and serviced after the scan.
- Address arithmetic is AW bits, wraps modulo 2^AW; no range check.
- busy = (state != IDLE).

## Timing
- Reset values: ram_addr=0, ram_wdata=0, ram_we=0, leds=0, busy=1 (state INIT_RD, k=0), pend=0, ptr=0, debouncer outputs=1 (released), counters=0.
- Reset asserted mid-RMW: ram_we drops asynchronously; the write in flight is abandoned and the word is unchanged; the init scan reruns on release.
- Init scan: 2*NCH cycles; busy falls in the cycle after the last INIT_WT.
- RMW: 4 cycles from IDLE with pend to return to IDLE (RD, WT, WR, then IDLE); ram_we is high for exactly one cycle; leds updates at the end of the WR cycle.
- Press latency with debounce: 2 (synchroniser) + DEBOUNCE_CYCLES + 1 (edge) cycles to pend; service follows after any RMWs queued ahead of it.
- Simultaneous presses on all NCH channels: serviced back-to-back in round-robin order, 4*NCH cycles total.

## Configuration
- RAM_TOGGLE_DEBOUNCE_EN defined: the debouncer updates its output only after DEBOUNCE_CYCLES consecutive cycles at the new synchronised level; any bounce resets the counter.
- Not defined: no counter; the debouncer output equals the synchronised input, so press latency is 3 cycles. Used for simulation speed. DEBOUNCE_CYCLES is then ignored.

## Structure
- Package ram_toggle_pkg: state enum (INIT_RD, INIT_WT, IDLE, RD, WT, WR); the function computing the debounce counter width, $clog2(DEBOUNCE_CYCLES+1).
- Sub-module btn_debounce (synchroniser, optional counter, released-high output), instantiated NCH times in a generate loop. Arbiter, FSM and pend live in the top.

## Test plan
- Reset with RAM words 1 and 2 preloaded with 0x1 and 0x0 -> after 4 cycles busy=0 and leds=2'b01.
- Single press on channel 0 (word 0x1) -> one cycle with ram_we=1, ram_addr=1, ram_wdata=0x0; leds[0]=0.
- Both buttons pressed in the same cycle with ptr=0 -> channel 0 RMW and then channel 1 RMW in 8 cycles; each word is XORed exactly once.
- Macro defined, DEBOUNCE_CYCLES=8, 3-cycle glitches on buttons[1] -> no pend and no RAM write; a 10-cycle hold -> exactly one RMW.
- Second press on channel 0 while pend[0] is set -> coalesced; exactly one write.
- rst_n pulled low during the WR cycle -> ram_we=0 immediately, word unchanged, init scan repeats.
